// File: rtl/core_seq_pkg.sv
// Shared definitions for the RV32I control sequencer: state encoding, NOP word,
// PC step, and the next-PC selection rule.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  // Jumps clear bit 0 of the target, taken branches use it as-is, everything else steps.
  function automatic logic [31:0] next_pc_f(input logic [31:0] pc_cur,
                                             input logic [31:0] target,
                                             input logic        is_jump,
                                             input logic        take_branch);
    logic [31:0] npc;
    if (is_jump) begin
      npc = {target[31:1], 1'b0};
    end else if (take_branch) begin
      npc = target;
    end else begin
      npc = pc_cur + PC_INC;
    end
    return npc;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshakes between the sequencer (master) and
// the memory side (slave).
interface core_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/seq_wait_timer.sv
// Handshake wait counter; only instantiated when SEQ_MEM_TIMEOUT_EN is defined.
// expired flags the waiting cycle that brings the count up to LIMIT.
module seq_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 32'd1);

  logic [7:0] count_q;

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (count_en) begin
      count_q <= count_q + 8'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign expired = count_en && (count_q == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory, writeback.
// Optional handshake timeout enabled by defining SEQ_MEM_TIMEOUT_EN.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  core_sequencer_if.master   mem,
  output logic [31:0]        instr,
  input  logic               dec_is_load,
  input  logic               dec_is_store,
  input  logic               dec_is_branch,
  input  logic               dec_is_jump,
  input  logic               dec_rd_valid,
  input  logic [31:0]        alu_result,
  input  logic               br_taken,
  output logic               rf_we,
  output logic [31:0]        pc,
  output logic [2:0]         state,
  output logic               err
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        imem_req_s, dmem_req_s, dmem_we_s, rf_we_s;
  logic [31:0] npc_s;
  logic        timeout_s;

`ifdef SEQ_MEM_TIMEOUT_EN
  logic wait_clear_s, wait_en_s;

  assign wait_clear_s = (state_q != ST_FETCH) && (state_q != ST_MEM);
  assign wait_en_s    = (imem_req_s && !mem.imem_ack) || (dmem_req_s && !mem.dmem_ack);

  seq_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wait_clear_s),
    .count_en (wait_en_s),
    .expired  (timeout_s)
  );
`else
  // Handshakes wait indefinitely; the limit only matters when the timer exists.
  assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  assign npc_s = next_pc_f(pc_q, alu_result, dec_is_jump, dec_is_branch && br_taken);

  // Sequencer state, PC, held instruction and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Next-state, PC update and handshake/strobe decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    err_d      = err_q;
    imem_req_s = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    rf_we_s    = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (mem.imem_ack) begin
          instr_d = mem.imem_rdata;
          state_d = ST_DECODE;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_is_load || dec_is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = dec_is_store;
        if (mem.dmem_ack) begin
          state_d = ST_WB;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        // The link write still happens when the jump target turns out misaligned.
        rf_we_s = dec_rd_valid && !dec_is_store && !dec_is_branch;
        if (npc_s[1]) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          pc_d    = npc_s;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        err_d   = 1'b1;
        state_d = ST_HALT;
      end
    endcase
  end

  assign mem.imem_req  = imem_req_s;
  assign mem.imem_addr = pc_q;
  assign mem.dmem_req  = dmem_req_s;
  assign mem.dmem_we   = dmem_we_s;
  assign rf_we         = rf_we_s;
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign state         = state_q;
  assign err           = err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed plus randomized bench for core_sequencer; expectations come from a
// per-instruction model of PC, rf_we, request lengths and CPI.
module tb_core_sequencer;
  import core_seq_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int unsigned TMO    = 4;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_JUMP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr, alu_result, pc;
  logic        dec_is_load, dec_is_store, dec_is_branch, dec_is_jump, dec_rd_valid;
  logic        br_taken, rf_we, err;
  logic [2:0]  state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic        exp_err;

  core_sequencer_if mem_if ();

  core_sequencer #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem_if),
    .instr         (instr),
    .dec_is_load   (dec_is_load),
    .dec_is_store  (dec_is_store),
    .dec_is_branch (dec_is_branch),
    .dec_is_jump   (dec_is_jump),
    .dec_rd_valid  (dec_rd_valid),
    .alu_result    (alu_result),
    .br_taken      (br_taken),
    .rf_we         (rf_we),
    .pc            (pc),
    .state         (state),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, ":rst_state"}, {29'd0, state}, 32'd0);
    chk({tag, ":rst_pc"}, pc, RST_PC);
    chk({tag, ":rst_instr"}, instr, 32'h0000_0013);
    chk({tag, ":rst_err"}, {31'd0, err}, 32'd0);
    chk({tag, ":rst_reqs"}, {28'd0, mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, rf_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, ":rel_state"}, {29'd0, state}, 32'd0);
    tick();
    chk({tag, ":first_fetch"}, {29'd0, state}, 32'd1);
    exp_pc  = RST_PC;
    exp_err = 1'b0;
  endtask

  // Runs one instruction from a FETCH negedge to the following FETCH/HALT negedge.
  task automatic run_instr(input int kind, input logic [31:0] alu, input logic br,
                           input logic rdv, input int iw, input int dw, input string tag);
    logic [31:0] word, tgt, pc0;
    logic        mis, exp_rf, mem_op;
    int          cyc, rf_cnt, dm_cnt, we_cnt, im_cnt;
    word = $urandom;
    pc0  = exp_pc;
    dec_is_load   = (kind == K_LOAD);
    dec_is_store  = (kind == K_STORE);
    dec_is_branch = (kind == K_BRANCH);
    dec_is_jump   = (kind == K_JUMP);
    dec_rd_valid  = rdv;
    alu_result    = alu;
    br_taken      = br;
    mem_op = (kind == K_LOAD) || (kind == K_STORE);
    if (kind == K_JUMP)                tgt = alu & 32'hFFFF_FFFE;
    else if (kind == K_BRANCH && br)   tgt = alu;
    else                               tgt = pc0 + 32'd4;
    mis    = tgt[1];
    exp_rf = rdv && (kind != K_STORE) && (kind != K_BRANCH);
    cyc = 0; rf_cnt = 0; dm_cnt = 0; we_cnt = 0; im_cnt = 0;

    #1;
    chk({tag, ":fetch_addr"}, mem_if.imem_addr, pc0);
    mem_if.imem_rdata = word;
    for (int w = 0; w <= iw; w++) begin
      mem_if.imem_ack = (w == iw);
      #1;
      im_cnt += int'(mem_if.imem_req);
      rf_cnt += int'(rf_we);
      tick(); cyc++;
    end
    chk({tag, ":imem_req_cycles"}, im_cnt, iw + 1);
    // Stray acks while nothing is requested must be ignored.
    mem_if.imem_ack   = 1'b1;
    mem_if.dmem_ack   = 1'($urandom);
    mem_if.imem_rdata = ~word;
    #1;
    chk({tag, ":decode_state"}, {29'd0, state}, 32'd2);
    chk({tag, ":instr"}, instr, word);
    rf_cnt += int'(rf_we);
    dm_cnt += int'(mem_if.dmem_req);
    tick(); cyc++;
    #1;
    chk({tag, ":exec_state"}, {29'd0, state}, 32'd3);
    rf_cnt += int'(rf_we);
    dm_cnt += int'(mem_if.dmem_req);
    tick(); cyc++;
    mem_if.imem_ack = 1'b0;
    if (mem_op) begin
      for (int w = 0; w <= dw; w++) begin
        mem_if.dmem_ack = (w == dw);
        #1;
        dm_cnt += int'(mem_if.dmem_req);
        we_cnt += int'(mem_if.dmem_req && mem_if.dmem_we);
        rf_cnt += int'(rf_we);
        tick(); cyc++;
      end
    end
    mem_if.dmem_ack = 1'b0;
    chk({tag, ":dmem_req_cycles"}, dm_cnt, mem_op ? dw + 1 : 0);
    chk({tag, ":dmem_we_cycles"}, we_cnt, (kind == K_STORE) ? dw + 1 : 0);
    mem_if.imem_ack = 1'($urandom);
    #1;
    chk({tag, ":wb_state"}, {29'd0, state}, 32'd5);
    chk({tag, ":wb_imem_req"}, {31'd0, mem_if.imem_req}, 32'd0);
    rf_cnt += int'(rf_we);
    tick(); cyc++;
    mem_if.imem_ack = 1'b0;
    #1;
    if (mis) exp_err = 1'b1;
    else     exp_pc  = tgt;
    chk({tag, ":rf_we_pulses"}, rf_cnt, int'(exp_rf));
    chk({tag, ":cpi"}, cyc, 4 + iw + (mem_op ? 1 + dw : 0));
    chk({tag, ":instr_hold"}, instr, word);
    chk({tag, ":pc"}, pc, exp_pc);
    chk({tag, ":err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, ":next_state"}, {29'd0, state}, mis ? 32'd6 : 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int          kind;
    mem_if.imem_ack = 1'b0; mem_if.imem_rdata = 32'd0; mem_if.dmem_ack = 1'b0;
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_branch = 1'b0; dec_is_jump = 1'b0;
    dec_rd_valid = 1'b0; alu_result = 32'd0; br_taken = 1'b0;
    exp_pc = RST_PC; exp_err = 1'b0;

    do_reset("por");
    run_instr(K_ALU,    32'h0000_1234, 1'b0, 1'b1, 0, 0, "addi");
    run_instr(K_LOAD,   32'h0000_0040, 1'b0, 1'b1, 3, 2, "lw");
    run_instr(K_STORE,  32'h0000_0044, 1'b0, 1'b0, 1, 1, "sw");
    run_instr(K_BRANCH, 32'h0000_0200, 1'b1, 1'b1, 0, 0, "beq_t");
    run_instr(K_BRANCH, 32'h0000_0400, 1'b0, 1'b1, 2, 0, "beq_nt");
    run_instr(K_JUMP,   32'h0000_0305, 1'b0, 1'b1, 0, 0, "jalr");
    run_instr(K_BRANCH, 32'hFFFF_FFFC, 1'b1, 1'b0, 0, 0, "to_top");
    run_instr(K_ALU,    32'h0000_0000, 1'b0, 1'b1, 0, 0, "wrap");

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 4));
      r = $urandom;
      if (kind == K_JUMP)        r = r & 32'hFFFF_FFFD;
      else if (kind == K_BRANCH) r = r & 32'hFFFF_FFFC;
      run_instr(kind, r, 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rnd");
    end

    // Reset while a load waits for its data ack.
    dec_is_load = 1'b1; dec_is_store = 1'b0; dec_is_branch = 1'b0; dec_is_jump = 1'b0;
    mem_if.imem_ack = 1'b1;
    tick();
    mem_if.imem_ack = 1'b0;
    tick(); tick();
    #1;
    chk("midmem:dmem_req", {31'd0, mem_if.dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midmem:outs", {28'd0, mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, rf_we}, 32'd0);
    chk("midmem:state", {29'd0, state}, 32'd0);
    chk("midmem:pc", pc, RST_PC);
    do_reset("midmem");

`ifdef SEQ_MEM_TIMEOUT_EN
    mem_if.imem_ack = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("tmo:still_fetch", {29'd0, state}, 32'd1);
    tick();
    #1;
    chk("tmo:err", {31'd0, err}, 32'd1);
    chk("tmo:state", {29'd0, state}, 32'd6);
    chk("tmo:imem_req", {31'd0, mem_if.imem_req}, 32'd0);
    do_reset("tmo");
`endif

    run_instr(K_ALU, 32'h0000_0000, 1'b0, 1'b1, 1, 0, "pre_halt");
    run_instr(K_JUMP, 32'h0000_0306, 1'b0, 1'b1, 0, 0, "jalr_mis");
    for (int i = 0; i < 5; i++) begin
      mem_if.imem_ack = 1'($urandom);
      mem_if.dmem_ack = 1'($urandom);
      tick();
      #1;
      chk("halt:state", {29'd0, state}, 32'd6);
      chk("halt:outs", {28'd0, mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, rf_we}, 32'd0);
      chk("halt:pc", pc, exp_pc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32I core. It fetches each instruction over the instruction-memory handshake and holds it stable for the registered decoder. It then steps through decode, execute, memory and writeback, generating data-memory requests, the register-file write strobe and the next PC. It sits between the memory interfaces and the decoder/ALU/register-file datapath, and is the only owner of the PC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT_CYCLES, 255, maximum wait cycles on a memory handshake; used only with SEQ_MEM_TIMEOUT_EN

- clk  in  1  core clock; everything is rising-edge
- rst_n  in  1  reset, asynchronous and active-low
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address, equal to pc
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  fetched word
- instr  out  32  held instruction word, drives the decoder
- dec_is_load  in  1  decoder class flag, valid from EXEC onward
- dec_is_store  in  1  decoder class flag, valid from EXEC onward
- dec_is_branch  in  1  decoder class flag, valid from EXEC onward
- dec_is_jump  in  1  decoder class flag (JAL/JALR), valid from EXEC onward
- dec_rd_valid  in  1  instruction writes rd
- alu_result  in  32  effective address or jump/branch target
- br_taken  in  1  branch condition from the ALU
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe
- pc  out  32  current PC
- state  out  3  current FSM state, for debug
- err  out  1  sticky fault flag

## Operation
- Encoding: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- RST → FETCH unconditionally.
- FETCH: imem_req=1 and imem_addr=pc, held until imem_ack. On ack, imem_rdata is registered into instr and the FSM moves to DECODE.
- DECODE: one cycle, covering the decoder's one-cycle register latency. Go to EXEC.
- EXEC: go to MEM if dec_is_load or dec_is_store, otherwise go to WB.
- MEM:
  - dmem_req=1 and dmem_we=dec_is_store, held until dmem_ack.
  - Go to WB on ack.
- WB:
  - rf_we=dec_rd_valid & ~dec_is_store & ~dec_is_branch, pulsed for exactly one cycle.
  - Next PC: jump → {alu_result[31:1],1'b0}; branch with br_taken → alu_result; otherwise pc+4.
  - Go to FETCH.
- Misaligned next PC (bit 1 set after masking): the PC is not updated, err is set, and the FSM goes to HALT. rf_we still pulses for a jump's link write.
- HALT: all request and strobe outputs are 0. Only rst_n leaves HALT.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- instr changes only on a FETCH ack, and is otherwise stable.

## Timing
- Reset values: state=RST, pc=RESET_PC, instr=32'h0000_0013 (NOP), err=0. imem_req, dmem_req, dmem_we and rf_we are 0.
- imem_req, dmem_req, dmem_we and rf_we are decoded combinationally from the registered state and inputs, with no extra latency.
- A zero-wait ack (in the same cycle as the req) is legal.
- Minimum CPI is 4 for ALU, branch and jump instructions, and 5 for loads and stores.
- The sequencer is single-outstanding: a request is never dropped or retracted before its ack.
- Ack while not requesting: ignored.
- rst_n asserted mid-handshake: the FSM returns to RST immediately. Outstanding memory transactions are abandoned, and the memory side must tolerate this.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to FETCH or MEM.
  - It increments each cycle that the request waits without an ack.
  - When it reaches TIMEOUT_CYCLES, err is set, the FSM goes to HALT and the request drops.
- SEQ_MEM_TIMEOUT_EN undefined: there is no counter, and handshakes wait indefinitely.

## Structure
- Package core_seq_pkg holds:
  - the state encoding constants;
  - the NOP constant 32'h0000_0013;
  - the PC increment 4.
- Optional sub-module seq_wait_timer, instantiated only under SEQ_MEM_TIMEOUT_EN, with ports clk, rst_n, clear, count_en and expired.
- The FSM and PC logic stay in core_sequencer.

## Test plan
- ADDI with zero-wait acks, RESET_PC=0x100: states go 1,2,3,5,1; rf_we pulses once in WB; pc becomes 0x104; fetch-to-fetch is 4 cycles.
- LW with imem_ack delayed 3 cycles and dmem_ack delayed 2: dmem_req is high for exactly 3 cycles with dmem_we=0; rf_we pulses once; pc advances by 4.
- Branch tests:
  - BEQ with br_taken=1, alu_result=0x200: pc=0x200 and rf_we stays 0.
  - BEQ with br_taken=0: pc=old+4.
- JALR with alu_result=0x305: pc=0x304 and rf_we=1. With alu_result=0x306: err=1, state=6, pc unchanged, no further imem_req.
- Reset during MEM: assert rst_n=0 while dmem_req=1. Outputs are 0 immediately; after release, pc=RESET_PC and state=RST then FETCH.
- With SEQ_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, withhold imem_ack: after 4 waiting cycles, err=1, state=6 and imem_req=0.
